// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state encoding and line levels for the FIFO-fed UART transmitter
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// rtl/fifo_uart_tx_if.sv - FIFO read-side handshake between the byte FIFO and the UART drain stage
interface fifo_uart_tx_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic              rd_req;
  logic              rd_ack;
  logic [DATA_W-1:0] data_out;

  modport master (input fifo_empty, input rd_ack, input data_out, output rd_req);
  modport slave  (output fifo_empty, output rd_ack, output data_out, input rd_req);
endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - baud counter emitting a one-cycle bit_done pulse every CLKS_PER_BIT cycles
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = !restart && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - drains the byte FIFO into 8N1 UART frames (8E1 with FIFO_UART_TX_PARITY_EN)
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tx_en,
  fifo_uart_tx_if.master  fifo,
  output logic            tx,
  output logic            busy
);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  uart_state_t       state, next_state;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              tx_lvl;
  logic              rd_req_q;
  logic              bit_done;
  logic              restart;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              par;
`endif

  // START is only entered from FETCH, and every other state entry lands on a
  // bit boundary where the counter wraps, so holding it in IDLE/FETCH suffices.
  assign restart = (state == IDLE) || (state == FETCH);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .bit_done (bit_done)
  );

  always_comb begin
    next_state = state;
    tx_lvl     = UART_IDLE_LVL;
    case (state)
      IDLE: begin
        if (tx_en && !fifo.fifo_empty) next_state = FETCH;
      end
      FETCH: begin
        if (fifo.rd_ack) next_state = START;
      end
      START: begin
        tx_lvl = UART_START_LVL;
        if (bit_done) next_state = DATA;
      end
      DATA: begin
        tx_lvl = shreg[0];
        if (bit_done && bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tx_lvl = par;
        if (bit_done) next_state = STOP;
      end
`endif
      STOP: begin
        tx_lvl = UART_STOP_LVL;
        if (bit_done) next_state = (tx_en && !fifo.fifo_empty) ? FETCH : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= UART_IDLE_LVL;
      rd_req_q <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      tx       <= tx_lvl;
      rd_req_q <= (next_state == FETCH);
      busy     <= (next_state != IDLE) || (state != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (state == FETCH && fifo.rd_ack) begin
      shreg   <= fifo.data_out;
      bit_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      par     <= ^fifo.data_out;
`endif
    end else if (state == DATA && bit_done) begin
      shreg   <= shreg >> 1;
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
  end

  assign fifo.rd_req = rd_req_q;

endmodule
